coprocessor_host_link: RTL

- Front-end stage that feeds the combinational matrix coprocessor and reads its result back.
- Receives a command word and packed matrix words from the HPS over a four-phase req/ack handshake.
- Holds operands stable at the coprocessor inputs, waits for settle and process-done, captures the 200-bit result plus overflow, and returns it to the HPS in 32-bit words over a second four-phase handshake.

---
 rtl/coprocessor_pkg.sv | 57 +++++
 rtl/four_phase_slave.sv | 27 ++
 rtl/coprocessor_host_link.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/coprocessor_pkg.sv
// Shared constants, state encoding and word-packing helpers for the matrix
// coprocessor host link.
package coprocessor_pkg;

  localparam int MATRIX_W = 200;
  localparam int WORD_W   = 32;
  localparam logic [2:0] LAST_IDX = 3'd6;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_SCL     = 3'b011;
  localparam logic [2:0] OP_NEG     = 3'b100;
  localparam logic [2:0] OP_TRN     = 3'b101;
  localparam logic [2:0] OP_OPP     = 3'b110;
  localparam logic [2:0] OP_INVALID = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_SEND    = 3'd6
  } state_t;

  function automatic logic needs_b(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

  // Word 6 carries only the top byte of the matrix.
  function automatic logic [MATRIX_W-1:0] put_word(input logic [MATRIX_W-1:0] m,
                                                   input logic [2:0] k,
                                                   input logic [WORD_W-1:0] w);
    logic [MATRIX_W-1:0] r;
    r = m;
    case (k)
      LAST_IDX: r[199:192] = w[7:0];
      3'd7:     r = m;
      default:  r[{k, 5'b00000} +: WORD_W] = w;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] result_word(input logic [MATRIX_W-1:0] res,
                                                    input logic [2:0] k,
                                                    input logic tmo,
                                                    input logic ovf);
    case (k)
      LAST_IDX: return {tmo, ovf, 22'd0, res[199:192]};
      3'd7:     return 32'd0;
      default:  return res[{k, 5'b00000} +: WORD_W];
    endcase
  endfunction

endpackage

// File: rtl/four_phase_slave.sv
// Slave side of a four-phase req/ack handshake: one accept pulse per request,
// ack raised after acceptance and dropped once the master releases req.
module four_phase_slave (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic req,
  output logic ack,
  output logic accept
);

  assign accept = enable & req & ~ack;

  // Ack register: set on accept, cleared after req is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
    end else if (accept) begin
      ack <= 1'b1;
    end else if (!req) begin
      ack <= 1'b0;
    end else begin
      ack <= ack;
    end
  end

endmodule

// File: rtl/coprocessor_host_link.sv
// Host link: loads command and operands over a write handshake, drives the
// coprocessor, captures its result and returns it over a read handshake.
module coprocessor_host_link
  import coprocessor_pkg::*;
#(
  parameter int WORDS_PER_MATRIX = 7,
  parameter int SETTLE_CYCLES    = 2,
  parameter int DONE_TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  hps_wr_data,
  input  logic         hps_wr_req,
  output logic         hps_wr_ack,
  input  logic         hps_rd_req,
  output logic         hps_rd_ack,
  output logic [31:0]  hps_rd_data,
  output logic         busy,
  output logic         result_ready,
  output logic         cmd_err,
  output logic         timeout_err,
  output logic [2:0]   cop_op_code,
  output logic [1:0]   cop_matrix_size,
  output logic [7:0]   cop_scalar,
  output logic [199:0] cop_matrix_a,
  output logic [199:0] cop_matrix_b,
  input  logic [199:0] cop_result,
  input  logic         cop_overflow,
  input  logic         cop_process_done
);

  localparam logic [2:0] LAST_WORD   = 3'(WORDS_PER_MATRIX - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(DONE_TIMEOUT - 1);

  state_t         state_r;
  state_t         state_s;
  logic           wr_en_s;
  logic           rd_en_s;
  logic           wr_accept_s;
  logic           rd_accept_s;
  logic [2:0]     wr_cnt_r;
  logic [2:0]     rd_cnt_r;
  logic [7:0]     settle_cnt_r;
  logic [7:0]     wait_cnt_r;
  logic           sent_last_r;
  logic [199:0]   result_r;
  logic           overflow_r;

  assign wr_en_s = (state_r == ST_IDLE) || (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B);
  assign rd_en_s = (state_r == ST_SEND) && !sent_last_r;

  four_phase_slave u_wr_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (wr_en_s),
    .req    (hps_wr_req),
    .ack    (hps_wr_ack),
    .accept (wr_accept_s)
  );

  four_phase_slave u_rd_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (rd_en_s),
    .req    (hps_rd_req),
    .ack    (hps_rd_ack),
    .accept (rd_accept_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_accept_s && (hps_wr_data[2:0] != OP_INVALID)) state_s = ST_LOAD_A;
        else state_s = ST_IDLE;
      end
      ST_LOAD_A: begin
        if (wr_accept_s && (wr_cnt_r == LAST_WORD))
          state_s = needs_b(cop_op_code) ? ST_LOAD_B : ST_SETTLE;
        else state_s = ST_LOAD_A;
      end
      ST_LOAD_B: begin
        if (wr_accept_s && (wr_cnt_r == LAST_WORD)) state_s = ST_SETTLE;
        else state_s = ST_LOAD_B;
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) state_s = ST_WAIT;
        else state_s = ST_SETTLE;
      end
      ST_WAIT: begin
        if (cop_process_done || (wait_cnt_r == WAIT_LAST)) state_s = ST_CAPTURE;
        else state_s = ST_WAIT;
      end
      ST_CAPTURE: state_s = ST_SEND;
      ST_SEND: begin
        // Leave on the edge where the final word's ack is released.
        if (sent_last_r && hps_rd_ack && !hps_rd_req) state_s = ST_IDLE;
        else state_s = ST_SEND;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != ST_IDLE);
    end
  end

  // Command decode and operand packing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cop_op_code     <= 3'd0;
      cop_matrix_size <= 2'd0;
      cop_scalar      <= 8'd0;
      cop_matrix_a    <= 200'd0;
      cop_matrix_b    <= 200'd0;
      wr_cnt_r        <= 3'd0;
    end else if (wr_accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (hps_wr_data[2:0] != OP_INVALID) begin
            cop_op_code     <= hps_wr_data[2:0];
            cop_matrix_size <= hps_wr_data[4:3];
            cop_scalar      <= hps_wr_data[12:5];
            cop_matrix_a    <= 200'd0;
            cop_matrix_b    <= 200'd0;
            wr_cnt_r        <= 3'd0;
          end
        end
        ST_LOAD_A: begin
          cop_matrix_a <= put_word(cop_matrix_a, wr_cnt_r, hps_wr_data);
          wr_cnt_r     <= (wr_cnt_r == LAST_WORD) ? 3'd0 : wr_cnt_r + 3'd1;
        end
        ST_LOAD_B: begin
          cop_matrix_b <= put_word(cop_matrix_b, wr_cnt_r, hps_wr_data);
          wr_cnt_r     <= (wr_cnt_r == LAST_WORD) ? 3'd0 : wr_cnt_r + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Settle and done-timeout counters, cleared outside their own state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_r <= 8'd0;
      wait_cnt_r   <= 8'd0;
    end else begin
      settle_cnt_r <= (state_r == ST_SETTLE) ? settle_cnt_r + 8'd1 : 8'd0;
      wait_cnt_r   <= (state_r == ST_WAIT) ? wait_cnt_r + 8'd1 : 8'd0;
    end
  end

  // Sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err      <= 1'b0;
      timeout_err  <= 1'b0;
      result_ready <= 1'b0;
    end else if (wr_accept_s && (state_r == ST_IDLE)) begin
      cmd_err      <= (hps_wr_data[2:0] == OP_INVALID);
      timeout_err  <= 1'b0;
      result_ready <= 1'b0;
    end else if ((state_r == ST_WAIT) && !cop_process_done && (wait_cnt_r == WAIT_LAST)) begin
      timeout_err <= 1'b1;
    end else if (state_r == ST_CAPTURE) begin
      result_ready <= 1'b1;
    end else if ((state_r == ST_SEND) && (state_s == ST_IDLE)) begin
      result_ready <= 1'b0;
    end
  end

  // Result capture and word-by-word readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= 200'd0;
      overflow_r  <= 1'b0;
      rd_cnt_r    <= 3'd0;
      sent_last_r <= 1'b0;
      hps_rd_data <= 32'd0;
    end else if (state_r == ST_CAPTURE) begin
      result_r    <= timeout_err ? 200'd0 : cop_result;
      overflow_r  <= timeout_err ? 1'b0 : cop_overflow;
      rd_cnt_r    <= 3'd0;
      sent_last_r <= 1'b0;
    end else if (rd_accept_s) begin
      hps_rd_data <= result_word(result_r, rd_cnt_r, timeout_err, overflow_r);
      if (rd_cnt_r == LAST_WORD) sent_last_r <= 1'b1;
      else rd_cnt_r <= rd_cnt_r + 3'd1;
    end
  end

endmodule
